// File: rtl/dffrsnq_init_seq_if.sv
// Request handshake plus the RN/SETN/capture pin bundle between a controller
// and the dffrsnq init sequencer.
interface dffrsnq_init_seq_if;
    logic REQ_VALID;
    logic REQ_SET;
    logic REQ_READY;
    logic RN;
    logic SETN;
    logic CAP_EN;
    logic BUSY;
    logic DONE;

    modport master (
        output REQ_VALID, REQ_SET,
        input  REQ_READY, RN, SETN, CAP_EN, BUSY, DONE
    );

    modport slave (
        input  REQ_VALID, REQ_SET,
        output REQ_READY, RN, SETN, CAP_EN, BUSY, DONE
    );
endinterface

// File: rtl/dffrsnq_init_seq.sv
// Sequencer producing registered, mutually exclusive RN/SETN pulses of fixed
// width followed by a recovery window before the flop bank may capture again.
module dffrsnq_init_seq #(
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic               CLK,
    input  logic               RST,
    dffrsnq_init_seq_if.slave  bus
);
    localparam bit         PARAMS_OK = (PULSE_CYC >= 1) && (PULSE_CYC <= 255) &&
                                       (RECOV_CYC >= 1) && (RECOV_CYC <= 255);
    localparam logic [7:0] P8 = PULSE_CYC[7:0];
    localparam logic [7:0] R8 = RECOV_CYC[7:0];

    typedef enum logic [1:0] {S_HOLD, S_ASSERT, S_RECOVER, S_IDLE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       set_lat, set_nxt;
    logic       req_flag, flag_nxt;
    logic       done_nxt, rn_nxt, setn_nxt, idle_nxt;
    logic       rn_q, setn_q, cap_q, rdy_q, busy_q, done_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        set_nxt   = set_lat;
        flag_nxt  = req_flag;
        done_nxt  = 1'b0;
        case (state)
            S_HOLD: begin
                state_nxt = S_RECOVER;
                cnt_nxt   = R8;
                flag_nxt  = 1'b0;
            end
            S_IDLE: begin
                if (bus.REQ_VALID) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = P8;
                    set_nxt   = bus.REQ_SET;
                    flag_nxt  = 1'b1;
                end
            end
            S_ASSERT: begin
                if (cnt <= 8'd1) begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = R8;
                end else begin
                    cnt_nxt   = cnt - 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt <= 8'd1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                    done_nxt  = req_flag;
                    flag_nxt  = 1'b0;
                end else begin
                    cnt_nxt   = cnt - 8'd1;
                end
            end
            default: state_nxt = S_HOLD;
        endcase

        // Pin levels come from the next state so every output is a plain flop.
        rn_nxt   = !(state_nxt == S_ASSERT && !set_nxt);
        setn_nxt = !(state_nxt == S_ASSERT &&  set_nxt);
        idle_nxt = (state_nxt == S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_HOLD;
            cnt      <= 8'd0;
            set_lat  <= 1'b0;
            req_flag <= 1'b0;
            rn_q     <= 1'b0;
            setn_q   <= 1'b1;
            cap_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            set_lat  <= set_nxt;
            req_flag <= flag_nxt;
            rn_q     <= rn_nxt;
            setn_q   <= setn_nxt;
            cap_q    <= idle_nxt;
            rdy_q    <= idle_nxt;
            busy_q   <= !idle_nxt;
            done_q   <= done_nxt;
        end
    end

    assign bus.RN        = rn_q;
    assign bus.SETN      = setn_q;
    assign bus.CAP_EN    = cap_q;
    assign bus.REQ_READY = rdy_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;

    a_params: assert property (@(posedge CLK) PARAMS_OK);
    a_excl:   assert property (@(posedge CLK) disable iff (RST) (rn_q || setn_q));
    a_cap:    assert property (@(posedge CLK) disable iff (RST) (!cap_q || (rn_q && setn_q)));
endmodule

// File: tb/tb_dffrsnq_init_seq.sv
// Randomized scoreboard bench: a per-cycle timeline model of the pin/handshake
// outputs plus a queue of accepted operations matched against DONE pulses.
module tb_dffrsnq_init_seq;
    localparam int P  = 2;
    localparam int R  = 2;
    localparam int P2 = 3;
    localparam int R2 = 1;
    localparam int NS = 4096;

    logic CLK = 1'b0;
    logic RST, RST2;
    always #5 CLK = ~CLK;

    dffrsnq_init_seq_if bus ();
    dffrsnq_init_seq_if bus2 ();

    dffrsnq_init_seq #(.PULSE_CYC(P),  .RECOV_CYC(R))  dut  (.CLK(CLK), .RST(RST),  .bus(bus));
    dffrsnq_init_seq #(.PULSE_CYC(P2), .RECOV_CYC(R2)) dut2 (.CLK(CLK), .RST(RST2), .bus(bus2));

    typedef struct { bit set; int e0; } op_t;

    int  slot = 0;
    int  checks = 0, failures = 0;
    bit  in_rst = 1'b0;
    bit  exp_rn [NS], exp_setn [NS], exp_cap [NS], exp_rdy [NS], exp_done [NS];
    op_t q [$];

    always @(posedge CLK) slot <= slot + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s slot=%0d got=%0d want=%0d", nm, slot, act, exp);
        end
    endtask

    task automatic set_slot(input int s, input bit rn, input bit setn, input bit cap,
                            input bit rdy, input bit done);
        if (s < NS) begin
            exp_rn[s] = rn; exp_setn[s] = setn; exp_cap[s] = cap;
            exp_rdy[s] = rdy; exp_done[s] = done;
        end
    endtask

    task automatic fill_idle(input int from);
        for (int c = from; c < NS; c++) set_slot(c, 1, 1, 1, 1, 0);
    endtask

    task automatic wait_slot();
        @(negedge CLK);
        #1;
    endtask

    // Drive inputs for the next edge and record what that edge must produce.
    task automatic drive(input bit r, input bit v, input bit st);
        int s, e;
        s = slot;
        e = s + 1;
        RST = r;
        bus.REQ_VALID = v;
        bus.REQ_SET = st;
        if (r) begin
            if (!in_rst) begin
                fill_idle(e);
                q.delete();
            end
            set_slot(e, 0, 1, 0, 0, 0);
            in_rst = 1'b1;
        end else if (in_rst) begin
            for (int k = 0; k < R; k++) set_slot(e + k, 1, 1, 0, 0, 0);
            in_rst = 1'b0;
        end else if (v && exp_rdy[s]) begin
            for (int k = 0; k < P + R; k++)
                set_slot(e + k, !(k < P && !st), !(k < P && st), 0, 0, 0);
            if (e + P + R < NS) exp_done[e + P + R] = 1'b1;
            q.push_back('{st, e});
        end
    endtask

    task automatic issue(input bit st);
        for (int k = 0; k < 20; k++) begin
            wait_slot();
            if (exp_rdy[slot]) begin
                drive(0, 1, st);
                break;
            end
            drive(0, 0, 0);
        end
        wait_slot();
        drive(0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            wait_slot();
            drive(0, 0, 0);
        end
    endtask

    // Monitor: per-cycle timeline comparison, invariants, and DONE scoreboard.
    int  ms;
    int  lo_pin = 0, lo_cnt = 0, last_pin = 0, last_w = 0;
    op_t mop;
    always @(negedge CLK) begin
        ms = slot;
        if (ms >= 1 && ms < NS) begin
            chk("rn",        bus.RN,        exp_rn[ms]);
            chk("setn",      bus.SETN,      exp_setn[ms]);
            chk("cap_en",    bus.CAP_EN,    exp_cap[ms]);
            chk("req_ready", bus.REQ_READY, exp_rdy[ms]);
            chk("busy",      bus.BUSY,      !exp_rdy[ms]);
            chk("done",      bus.DONE,      exp_done[ms]);
            chk("rn_setn_excl", bus.RN | bus.SETN, 1);
            chk("cap_vs_pins",  !bus.CAP_EN || (bus.RN && bus.SETN), 1);
            chk("ready_not_busy", bus.REQ_READY ^ bus.BUSY, 1);

            if (bus.RN === 1'b0) begin
                if (lo_pin == 1) lo_cnt++; else begin lo_pin = 1; lo_cnt = 1; end
            end else if (bus.SETN === 1'b0) begin
                if (lo_pin == 2) lo_cnt++; else begin lo_pin = 2; lo_cnt = 1; end
            end else if (lo_pin != 0) begin
                last_pin = lo_pin;
                last_w   = lo_cnt;
                lo_pin   = 0;
            end

            if (bus.DONE === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected slot=%0d got=DONE want=no DONE", ms);
                end else begin
                    mop = q.pop_front();
                    chk("done_latency", ms - mop.e0, P + R);
                    chk("pulse_pin",    last_pin, mop.set ? 2 : 1);
                    chk("pulse_width",  last_w, P);
                end
            end
        end
    end

    // Second configuration: one preset with PULSE_CYC=3, RECOV_CYC=1.
    initial begin
        RST2 = 1'b1;
        bus2.REQ_VALID = 1'b0;
        bus2.REQ_SET = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST2 = 1'b0;
        @(negedge CLK);
        chk("d2_recover_ready", bus2.REQ_READY, 0);
        chk("d2_recover_rn",    bus2.RN, 1);
        @(negedge CLK);
        chk("d2_idle_ready", bus2.REQ_READY, 1);
        chk("d2_idle_cap",   bus2.CAP_EN, 1);
        #1;
        bus2.REQ_VALID = 1'b1;
        bus2.REQ_SET = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("d2_setn", bus2.SETN,   (k >= P2) ? 1 : 0);
            chk("d2_rn",   bus2.RN,     1);
            chk("d2_cap",  bus2.CAP_EN, (k >= P2 + R2) ? 1 : 0);
            chk("d2_done", bus2.DONE,   (k == P2 + R2) ? 1 : 0);
            #1 bus2.REQ_VALID = 1'b0;
        end
    end

    initial begin
        fill_idle(0);
        RST = 1'b1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_SET = 1'b0;
        set_slot(1, 0, 1, 0, 0, 0);
        in_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_slot();
            drive(1, 0, 0);
        end
        wait_slot();
        drive(0, 0, 0);

        issue(0);
        idle(8);
        issue(1);
        idle(8);

        for (int k = 0; k < 60; k++) begin
            wait_slot();
            drive(0, 1, k[0]);
        end
        idle(6);

        // Reset lands while the SETN pulse is still low.
        issue(1);
        wait_slot();
        drive(1, 0, 0);
        wait_slot();
        drive(1, 0, 0);
        wait_slot();
        drive(0, 0, 0);
        idle(6);

        for (int k = 0; k < 1500; k++) begin
            bit r;
            wait_slot();
            r = in_rst ? ($urandom_range(1, 0) == 1) : ($urandom_range(249, 0) == 0);
            drive(r, $urandom_range(2, 0) != 0, $urandom_range(1, 0) == 1);
        end
        idle(12);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dffrsnq_init_seq.md
# dffrsnq_init_seq

Synchronous sequencer that drives the active-low asynchronous clear (RN) and preset (SETN) pins of a bank of dffrsnq flops from a single clock domain. It turns one-shot set/clear requests into clean, registered, mutually exclusive RN/SETN pulses of guaranteed minimum width. After each pulse it holds a recovery window before re-enabling data capture, so the downstream flops' recovery/removal and RN/SETN setup/hold checks are met by construction. The block sits directly upstream of the flop bank; its RN/SETN outputs fan out to every cell's RN/SETN pins, and its CAP_EN output gates the bank's D-path.

## Interface
Parameters:
- PULSE_CYC, 2: cycles RN or SETN is held low per request; legal range 1..255.
- RECOV_CYC, 2: cycles both pins are held high, with capture disabled, after release; legal range 1..255.

Ports:
- CLK  input  1  sole clock; all state changes on posedge CLK.
- RST  input  1  reset, synchronous, active-high.
- REQ_VALID  input  1  request present.
- REQ_SET  input  1  1 = preset (SETN pulse), 0 = clear (RN pulse); sampled only at accept.
- REQ_READY  output  1  block can accept a request; high only in IDLE.
- RN  output  1  to the flop bank's RN pins; active-low clear.
- SETN  output  1  to the flop bank's SETN pins; active-low preset.
- CAP_EN  output  1  high when the downstream D-path may capture.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when a requested operation completes.

## Operation
- States: HOLD (reset), ASSERT, RECOVER, IDLE.
- RST high:
  - Next edge forces HOLD: RN=0, SETN=1, CAP_EN=0, REQ_READY=0, BUSY=1, DONE=0.
  - These are the reset values of all outputs; the flop bank stays cleared through reset.
- HOLD, with RST low at an edge: go to RECOVER. RN=1, counter=RECOV_CYC, internal req_flag=0.
- IDLE:
  - REQ_READY=1, CAP_EN=1, BUSY=0, RN=SETN=1.
  - Accept occurs on an edge where REQ_VALID&REQ_READY.
  - On accept: latch REQ_SET, go to ASSERT, counter=PULSE_CYC, req_flag=1.
  - In ASSERT: SETN=0 if the latched REQ_SET=1, else RN=0. CAP_EN=0.
- ASSERT: decrement the counter each edge. When it would reach 0: go to RECOVER, release the pin (RN=SETN=1), counter=RECOV_CYC.
- RECOVER:
  - RN=SETN=1, CAP_EN=0.
  - Counter expiry leads to IDLE.
  - DONE=1 for the first IDLE cycle only if req_flag=1; req_flag is then cleared. No DONE after the reset-induced recovery.
- Invariants:
  - RN and SETN are never both 0.
  - RN and SETN are driven directly from flops (no combinational glitches).
  - At least RECOV_CYC cycles separate the release of one pin and the assertion of either pin.
  - CAP_EN is 0 whenever either pin is low or recovery is in progress.
- REQ_VALID/REQ_SET changes outside accept edges are ignored. A request held while BUSY waits; it is not dropped.
- Counters are 8-bit. Values of 0 or above 255 are illegal and flagged with a simulation-time assertion.

## Timing
- Accept at edge E0:
  - RN/SETN low during cycles E0+1 .. E0+PULSE_CYC (exactly PULSE_CYC cycles).
  - RECOVER during cycles E0+PULSE_CYC+1 .. E0+PULSE_CYC+RECOV_CYC.
  - IDLE, with REQ_READY=CAP_EN=DONE=1, from cycle E0+PULSE_CYC+RECOV_CYC+1.
- Back-to-back throughput: one request per PULSE_CYC+RECOV_CYC+1 cycles. A request held high is accepted on the DONE cycle.
- Reset release at edge R0: RN rises in cycle R0+1; IDLE from cycle R0+RECOV_CYC+1.
- RST asserted mid-ASSERT or mid-RECOVER: HOLD values on the next edge.
  - An in-flight SETN pulse is cut: SETN=1 and RN=0 in the same cycle.
  - The pending DONE is lost.
- RST has priority over a simultaneous accept.

## Test plan
- Reset, PULSE_CYC=2, RECOV_CYC=2: hold RST 3 cycles, release at R0 -> RN=0, CAP_EN=0 during reset; RN=1 at R0+1; REQ_READY=CAP_EN=1 at R0+3; DONE never pulses.
- Clear request, REQ_SET=0, accepted at E0 -> RN=0 at E0+1..E0+2; SETN stays 1; CAP_EN=0 through E0+4; DONE=1 only at E0+5.
- Preset request, REQ_SET=1, PULSE_CYC=3, RECOV_CYC=1 -> SETN=0 for exactly 3 cycles; RN stays 1; DONE 5 cycles after accept.
- Back-to-back: REQ_VALID held high, REQ_SET toggling every cycle -> accepts spaced 5 cycles apart (default parameters); each op uses REQ_SET as sampled at its accept edge; RN/SETN never both 0; at least 2 cycles high between pulses.
- RST asserted at cycle 2 of a SETN pulse -> next cycle SETN=1, RN=0, BUSY=1, no DONE; normal recovery after release.
- Monitor throughout random traffic: RN&SETN never both 0; CAP_EN=0 whenever !RN|!SETN; REQ_READY==!BUSY.
